// File: rtl/trig_pkg.sv
// Shared types and sizing helpers for the trigger scheduler.
// Cycle counts are derived from the clock rate and microsecond timings.
package trig_pkg;

    typedef enum logic [1:0] {IDLE, FIRE, HOLDOFF} trig_state_t;

    function automatic int qual_cyc(input int mhz, input int us);
        return mhz * us;
    endfunction

    function automatic int hold_cyc(input int mhz, input int us);
        return mhz * us;
    endfunction

    function automatic int at_least1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int qual_w(input int q);
        return at_least1($clog2(q + 1));
    endfunction

    function automatic int fsm_w(input int r, input int h);
        return at_least1($clog2((r > h) ? r : h));
    endfunction

    function automatic int id_w(input int n);
        return at_least1($clog2(n));
    endfunction

endpackage

// File: rtl/trig_qual.sv
// Per-source synchroniser and minimum-width qualifier.
// Emits one registered qual pulse per sufficiently long high level.
module trig_qual
    import trig_pkg::*;
#(
    parameter int QUAL_CYC = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic en,
    output logic qual
);

    localparam int QW = qual_w(QUAL_CYC);

    logic          s1;
    logic          s2;
    logic [QW-1:0] cnt;

    // Counter saturates at QUAL_CYC so a long level yields a single qual.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            qual <= 1'b0;
        end else begin
            s1 <= src;
            s2 <= s1;
            if (!en || !s2) begin
                cnt  <= '0;
                qual <= 1'b0;
            end else if (cnt != QW'(QUAL_CYC)) begin
                cnt  <= cnt + QW'(1);
                qual <= (cnt == QW'(QUAL_CYC - 1));
            end else begin
                qual <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/trig_sched.sv
// Trigger scheduler: qualifies sources, queues events, grants round-robin
// and issues one fixed-width trig_rst_o pulse per grant with hold-off.
module trig_sched
    import trig_pkg::*;
#(
    parameter int N_SRC         = 3,
    parameter int CLK_MHZ       = 20,
    parameter int MIN_WIDTH_US  = 50,
    parameter int RST_PULSE_CYC = 3,
    parameter int HOLDOFF_US    = 1000,
    parameter int CNT_W         = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [N_SRC-1:0]         trig_src_i,
    input  logic [N_SRC-1:0]         src_en_i,
    output logic                     trig_rst_o,
    output logic [id_w(N_SRC)-1:0]   grant_id_o,
    output logic                     busy_o,
    output logic [N_SRC-1:0]         pending_o,
    output logic [CNT_W-1:0]         event_cnt_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    localparam int QUAL_CYC = qual_cyc(CLK_MHZ, MIN_WIDTH_US);
    localparam int HOLD_CYC = hold_cyc(CLK_MHZ, HOLDOFF_US);
    localparam int IDW      = id_w(N_SRC);
    localparam int FW       = fsm_w(RST_PULSE_CYC, HOLD_CYC);
    localparam int DW       = CNT_W + 1;

    trig_state_t      state;
    logic [FW-1:0]    fcnt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   idx;
    logic [IDW-1:0]   sel;
    logic             found;
    logic [N_SRC-1:0] qual;
    logic [N_SRC-1:0] grant;
    logic [N_SRC-1:0] lost;
    logic [DW-1:0]    drop_sum;

    for (genvar g = 0; g < N_SRC; g++) begin : g_qual
        trig_qual #(.QUAL_CYC(QUAL_CYC)) u_qual (
            .clk  (sys_clk),
            .rst  (sys_rst),
            .src  (trig_src_i[g]),
            .en   (src_en_i[g]),
            .qual (qual[g])
        );
    end

    // Search begins one past the last grant and wraps at N_SRC-1.
    always_comb begin
        idx   = ptr;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (idx == IDW'(N_SRC - 1)) ? '0 : idx + IDW'(1);
            if (!found && pending_o[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign grant = (state == IDLE && found) ? (N_SRC'(1) << sel) : '0;
    assign lost  = qual & pending_o & ~grant;

    always_comb begin
        drop_sum = {1'b0, drop_cnt_o};
        for (int i = 0; i < N_SRC; i++) begin
            if (lost[i]) drop_sum = drop_sum + DW'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pending_o  <= '0;
            drop_cnt_o <= '0;
        end else begin
            pending_o  <= (pending_o & ~grant & src_en_i) | qual;
            drop_cnt_o <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            fcnt        <= '0;
            ptr         <= IDW'(N_SRC - 1);
            grant_id_o  <= '0;
            trig_rst_o  <= 1'b0;
            busy_o      <= 1'b0;
            event_cnt_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state       <= FIRE;
                        grant_id_o  <= sel;
                        ptr         <= sel;
                        event_cnt_o <= event_cnt_o + CNT_W'(1);
                        trig_rst_o  <= 1'b1;
                        busy_o      <= 1'b1;
                        fcnt        <= FW'(RST_PULSE_CYC - 1);
                    end
                end
                FIRE: begin
                    if (fcnt == '0) begin
                        state      <= HOLDOFF;
                        trig_rst_o <= 1'b0;
                        fcnt       <= FW'(HOLD_CYC - 1);
                    end else begin
                        fcnt <= fcnt - FW'(1);
                    end
                end
                HOLDOFF: begin
                    if (fcnt == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        fcnt <= fcnt - FW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trig_sched.sv
// Directed bench for trig_sched with QUAL_CYC=20, HOLD_CYC=40, 3-cycle pulse.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_trig_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [2:0]  trig_src_i = '0;
    logic [2:0]  src_en_i = 3'b111;
    logic        trig_rst_o;
    logic [1:0]  grant_id_o;
    logic        busy_o;
    logic [2:0]  pending_o;
    logic [15:0] event_cnt_o;
    logic [15:0] drop_cnt_o;

    int checks = 0;
    int failures = 0;

    trig_sched #(
        .N_SRC         (3),
        .CLK_MHZ       (20),
        .MIN_WIDTH_US  (1),
        .RST_PULSE_CYC (3),
        .HOLDOFF_US    (2),
        .CNT_W         (16)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .trig_src_i  (trig_src_i),
        .src_en_i    (src_en_i),
        .trig_rst_o  (trig_rst_o),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o),
        .pending_o   (pending_o),
        .event_cnt_o (event_cnt_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 200) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        // reset state
        tick(3);
        check("rst_trig", {31'd0, trig_rst_o}, 0);
        check("rst_grant", {30'd0, grant_id_o}, 0);
        check("rst_busy", {31'd0, busy_o}, 0);
        check("rst_pend", {29'd0, pending_o}, 0);
        check("rst_evt", {16'd0, event_cnt_o}, 0);
        check("rst_drop", {16'd0, drop_cnt_o}, 0);
        sys_rst = 1'b0;
        tick(2);

        // 1: src0 high 30 cycles, pulse rises after edge 23
        trig_src_i = 3'b001;
        tick(23);
        check("t1_pre", {31'd0, trig_rst_o}, 0);
        check("t1_pend", {29'd0, pending_o}, 3'b001);
        tick(1);
        check("t1_rise", {31'd0, trig_rst_o}, 1);
        check("t1_grant", {30'd0, grant_id_o}, 0);
        check("t1_evt", {16'd0, event_cnt_o}, 1);
        check("t1_busy", {31'd0, busy_o}, 1);
        tick(2);
        check("t1_hi3", {31'd0, trig_rst_o}, 1);
        tick(1);
        check("t1_fall", {31'd0, trig_rst_o}, 0);
        tick(3);
        trig_src_i = 3'b000;
        tick(36);
        check("t1_hold_end", {31'd0, busy_o}, 1);
        tick(1);
        check("t1_idle", {31'd0, busy_o}, 0);
        check("t1_evt_end", {16'd0, event_cnt_o}, 1);

        // 2: src1 19-cycle high is ignored, 25-cycle high fires once
        trig_src_i = 3'b010;
        tick(19);
        trig_src_i = 3'b000;
        tick(5);
        check("t2_short_trig", {31'd0, trig_rst_o}, 0);
        check("t2_short_pend", {29'd0, pending_o}, 0);
        check("t2_short_evt", {16'd0, event_cnt_o}, 1);
        trig_src_i = 3'b010;
        tick(23);
        check("t2_pre", {31'd0, trig_rst_o}, 0);
        tick(1);
        check("t2_rise", {31'd0, trig_rst_o}, 1);
        check("t2_grant", {30'd0, grant_id_o}, 1);
        check("t2_evt", {16'd0, event_cnt_o}, 2);
        tick(1);
        trig_src_i = 3'b000;
        wait_idle("t2_idle");
        tick(10);
        check("t2_evt_end", {16'd0, event_cnt_o}, 2);
        check("t2_drop", {16'd0, drop_cnt_o}, 0);

        // 5: reset in second FIRE cycle drops trig_rst_o asynchronously
        trig_src_i = 3'b100;
        tick(24);
        check("t5_rise", {31'd0, trig_rst_o}, 1);
        check("t5_grant", {30'd0, grant_id_o}, 2);
        tick(1);
        #1 sys_rst = 1'b1;
        #1;
        check("t5_async_trig", {31'd0, trig_rst_o}, 0);
        check("t5_async_evt", {16'd0, event_cnt_o}, 0);
        check("t5_async_busy", {31'd0, busy_o}, 0);
        trig_src_i = 3'b000;
        tick(2);
        sys_rst = 1'b0;
        tick(2);
        check("t5_grant0", {30'd0, grant_id_o}, 0);
        check("t5_pend0", {29'd0, pending_o}, 0);
        check("t5_drop0", {16'd0, drop_cnt_o}, 0);

        // 3: all sources qualify together, served 0,1,2 at 44-cycle spacing
        trig_src_i = 3'b111;
        tick(23);
        check("t3_pend111", {29'd0, pending_o}, 3'b111);
        check("t3_pre", {31'd0, trig_rst_o}, 0);
        tick(1);
        check("t3_g0", {30'd0, grant_id_o}, 0);
        check("t3_rise0", {31'd0, trig_rst_o}, 1);
        check("t3_pend110", {29'd0, pending_o}, 3'b110);
        tick(6);
        trig_src_i = 3'b000;
        tick(37);
        check("t3_pre1", {31'd0, trig_rst_o}, 0);
        tick(1);
        check("t3_rise1", {31'd0, trig_rst_o}, 1);
        check("t3_g1", {30'd0, grant_id_o}, 1);
        check("t3_pend100", {29'd0, pending_o}, 3'b100);
        tick(43);
        check("t3_pre2", {31'd0, trig_rst_o}, 0);
        tick(1);
        check("t3_rise2", {31'd0, trig_rst_o}, 1);
        check("t3_g2", {30'd0, grant_id_o}, 2);
        check("t3_pend000", {29'd0, pending_o}, 0);
        check("t3_evt", {16'd0, event_cnt_o}, 3);
        wait_idle("t3_idle");

        // 4: src2 qualifies three times while src0 is served, two drops
        trig_src_i = 3'b101;
        tick(20);
        trig_src_i[2] = 1'b0;
        tick(1);
        trig_src_i[2] = 1'b1;
        tick(3);
        check("t4_rise0", {31'd0, trig_rst_o}, 1);
        check("t4_g0", {30'd0, grant_id_o}, 0);
        check("t4_pend", {29'd0, pending_o}, 3'b100);
        tick(6);
        trig_src_i[0] = 1'b0;
        tick(11);
        trig_src_i[2] = 1'b0;
        tick(1);
        trig_src_i[2] = 1'b1;
        tick(8);
        check("t4_drop1", {16'd0, drop_cnt_o}, 1);
        tick(12);
        trig_src_i[2] = 1'b0;
        tick(4);
        check("t4_drop2", {16'd0, drop_cnt_o}, 2);
        check("t4_pend_wait", {29'd0, pending_o}, 3'b100);
        check("t4_pre2", {31'd0, trig_rst_o}, 0);
        tick(2);
        check("t4_rise2", {31'd0, trig_rst_o}, 1);
        check("t4_g2", {30'd0, grant_id_o}, 2);
        check("t4_pend_clr", {29'd0, pending_o}, 0);
        check("t4_evt", {16'd0, event_cnt_o}, 5);
        wait_idle("t4_idle");
        tick(5);
        check("t4_evt_end", {16'd0, event_cnt_o}, 5);

        // 6: disabling src1 during HOLDOFF discards its request silently
        trig_src_i = 3'b001;
        tick(10);
        trig_src_i[1] = 1'b1;
        tick(14);
        check("t6_rise", {31'd0, trig_rst_o}, 1);
        check("t6_g0", {30'd0, grant_id_o}, 0);
        tick(6);
        trig_src_i[0] = 1'b0;
        tick(10);
        check("t6_pend1", {29'd0, pending_o}, 3'b010);
        src_en_i = 3'b101;
        tick(1);
        check("t6_pend_clr", {29'd0, pending_o}, 0);
        trig_src_i[1] = 1'b0;
        tick(4);
        src_en_i = 3'b111;
        wait_idle("t6_idle");
        tick(30);
        check("t6_evt", {16'd0, event_cnt_o}, 6);
        check("t6_drop", {16'd0, drop_cnt_o}, 2);
        check("t6_trig", {31'd0, trig_rst_o}, 0);
        check("t6_busy", {31'd0, busy_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
